// File: rtl/equation2_hint_if.sv
// Handshake bundle between the hint/solver block and its consumer (equation checker or bench).
interface equation2_hint_if;
    logic       start;
    logic [6:0] OngoingTimer;
    logic [7:0] DataOut;
    logic       Go;
    logic       busy;
    logic       found;
    logic       done;

    modport master (
        input  start, OngoingTimer,
        output DataOut, Go, busy, found, done
    );

    modport slave (
        output start, OngoingTimer,
        input  DataOut, Go, busy, found, done
    );
endinterface

// File: rtl/equation2_hint.sv
// Brute-force solver for x*x*z + x*y == target (8-bit), replaying the first hit
// as x, y, z on the DataOut/Go handshake a player would use.
module equation2_hint #(
    parameter int MAXV    = 15,
    parameter int GO_HIGH = 2,
    parameter int GO_LOW  = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    equation2_hint_if.master  bus
);

    localparam logic [7:0]  MAX8    = 8'(MAXV);
    localparam logic [15:0] HI_LAST = 16'(GO_HIGH - 1);
    localparam logic [15:0] LO_LAST = 16'(GO_LOW - 1);

    typedef enum logic [2:0] {IDLE, SEARCH, SETUP, GO_HI, GO_LO, DONE} state_t;

    state_t      state;
    logic [7:0]  x, y, z, target;
    logic [7:0]  hx, hy, hz;
    logic [1:0]  idx;
    logic [15:0] cnt;
    logic [7:0]  dout_q;
    logic        go_q, busy_q, found_q, done_q;
    logic [7:0]  r;
    logic        hit;
    logic        last_triple;

    // Every intermediate is cut to 8 bits, mirroring the checker's registers.
    function automatic logic [7:0] eval_r(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        logic [7:0] sq, t1, t2;
        sq = a * a;
        t1 = sq * c;
        t2 = a * b;
        return t1 + t2;
    endfunction

    function automatic logic [7:0] pick(input logic [1:0] i, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c);
        case (i)
            2'd0:    return a;
            2'd1:    return b;
            default: return c;
        endcase
    endfunction

    assign r           = eval_r(x, y, z);
    assign hit         = (r == target);
    assign last_triple = (x == MAX8) && (y == MAX8) && (z == MAX8);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            target  <= '0;
            hx      <= '0;
            hy      <= '0;
            hz      <= '0;
            idx     <= '0;
            cnt     <= '0;
            dout_q  <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            found_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        target  <= {1'b0, bus.OngoingTimer};
                        x       <= '0;
                        y       <= '0;
                        z       <= '0;
                        busy_q  <= 1'b1;
                        found_q <= 1'b0;
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        hx     <= x;
                        hy     <= y;
                        hz     <= z;
                        idx    <= 2'd0;
                        dout_q <= x;
                        state  <= SETUP;
                    end else if (last_triple) begin
                        found_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else if (z != MAX8) begin
                        z <= z + 8'd1;
                    end else begin
                        // Limit compare, not overflow, ends each digit so MAXV=255 cannot wrap.
                        z <= '0;
                        if (y != MAX8) begin
                            y <= y + 8'd1;
                        end else begin
                            y <= '0;
                            x <= x + 8'd1;
                        end
                    end
                end
                SETUP: begin
                    go_q  <= 1'b1;
                    cnt   <= '0;
                    state <= GO_HI;
                end
                GO_HI: begin
                    if (cnt == HI_LAST) begin
                        go_q  <= 1'b0;
                        cnt   <= '0;
                        state <= GO_LO;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GO_LO: begin
                    if (cnt == LO_LAST) begin
                        if (idx != 2'd2) begin
                            idx    <= idx + 2'd1;
                            dout_q <= pick(idx + 2'd1, hx, hy, hz);
                            state  <= SETUP;
                        end else begin
                            found_q <= 1'b1;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.Go      = go_q;
    assign bus.busy    = busy_q;
    assign bus.found   = found_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_equation2_hint.sv
// Randomized bench for equation2_hint: three parameterizations, per-cycle trace model.
module tb_equation2_hint;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] timer = '0;
    int         sel = 0;

    always #5 clk = ~clk;

    equation2_hint_if if_a ();
    equation2_hint_if if_b ();
    equation2_hint_if if_c ();

    assign if_a.start = start && (sel == 0);
    assign if_b.start = start && (sel == 1);
    assign if_c.start = start && (sel == 2);
    assign if_a.OngoingTimer = timer;
    assign if_b.OngoingTimer = timer;
    assign if_c.OngoingTimer = timer;

    equation2_hint #(.MAXV(15), .GO_HIGH(2), .GO_LOW(2)) dut_a (.Clock(clk), .Resetn(rst_n), .bus(if_a));
    equation2_hint #(.MAXV(1),  .GO_HIGH(2), .GO_LOW(2)) dut_b (.Clock(clk), .Resetn(rst_n), .bus(if_b));
    equation2_hint #(.MAXV(15), .GO_HIGH(3), .GO_LOW(1)) dut_c (.Clock(clk), .Resetn(rst_n), .bus(if_c));

    typedef struct packed {
        logic [7:0] d;
        logic       go;
        logic       busy;
        logic       found;
        logic       done;
    } obs_t;

    obs_t obs;
    always_comb begin
        obs = '0;
        case (sel)
            0:       obs = {if_a.DataOut, if_a.Go, if_a.busy, if_a.found, if_a.done};
            1:       obs = {if_b.DataOut, if_b.Go, if_b.busy, if_b.found, if_b.done};
            default: obs = {if_c.DataOut, if_c.Go, if_c.busy, if_c.found, if_c.done};
        endcase
    end

    int         cfg_m  [3] = '{15, 1, 15};
    int         cfg_gh [3] = '{2, 2, 3};
    int         cfg_gl [3] = '{2, 2, 1};
    logic [7:0] prev_d [3] = '{8'd0, 8'd0, 8'd0};

    obs_t       trace[$];
    obs_t       trace_next[$];
    int         tr_idx = 0;
    int         done_cycle = 0;
    logic [7:0] cap[$];
    logic       go_d = 1'b0;
    int         model_k = -1;
    bit         model_found = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    function automatic obs_t mk(input logic [7:0] d, input logic go, input logic busy,
                                input logic found, input logic done);
        obs_t e;
        e.d = d; e.go = go; e.busy = busy; e.found = found; e.done = done;
        return e;
    endfunction

    // Expected outputs for every cycle after the accepted start, from the block's rules.
    task automatic mk_trace(input int s, input int tgt);
        int         m, k, n_search;
        bit         hit;
        logic [7:0] v[3];
        m = cfg_m[s];
        hit = 1'b0;
        k = 0;
        v = '{8'd0, 8'd0, 8'd0};
        for (int x = 0; x <= m; x++)
            for (int y = 0; y <= m; y++)
                for (int z = 0; z <= m; z++)
                    if (!hit && ((x * x * z + x * y) % 256) == tgt) begin
                        hit  = 1'b1;
                        k    = x * (m + 1) * (m + 1) + y * (m + 1) + z;
                        v[0] = 8'(x); v[1] = 8'(y); v[2] = 8'(z);
                    end
        model_found = hit;
        model_k     = hit ? k : -1;
        n_search    = hit ? k + 1 : (m + 1) * (m + 1) * (m + 1);
        trace_next.delete();
        repeat (n_search) trace_next.push_back(mk(prev_d[s], 1'b0, 1'b1, 1'b0, 1'b0));
        if (hit) begin
            for (int vi = 0; vi < 3; vi++) begin
                trace_next.push_back(mk(v[vi], 1'b0, 1'b1, 1'b0, 1'b0));
                repeat (cfg_gh[s]) trace_next.push_back(mk(v[vi], 1'b1, 1'b1, 1'b0, 1'b0));
                repeat (cfg_gl[s]) trace_next.push_back(mk(v[vi], 1'b0, 1'b1, 1'b0, 1'b0));
            end
            prev_d[s] = v[2];
        end
        trace_next.push_back(mk(prev_d[s], 1'b0, 1'b1, hit, 1'b1));
        repeat (2) trace_next.push_back(mk(prev_d[s], 1'b0, 1'b0, hit, 1'b0));
    endtask

    // Single compare process: trace cycles while a run is armed, idle sanity otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (tr_idx < trace.size()) begin
                n_checks++;
                if (obs !== trace[tr_idx]) begin
                    n_fail++;
                    $display("FAIL trace cycle %0d dut %0d: got d=%0d go=%b busy=%b found=%b done=%b, required d=%0d go=%b busy=%b found=%b done=%b",
                             tr_idx + 1, sel, obs.d, obs.go, obs.busy, obs.found, obs.done,
                             trace[tr_idx].d, trace[tr_idx].go, trace[tr_idx].busy,
                             trace[tr_idx].found, trace[tr_idx].done);
                end
                if (obs.done === 1'b1 && done_cycle == 0) done_cycle = tr_idx + 1;
                if (obs.go === 1'b1 && go_d !== 1'b1) cap.push_back(obs.d);
                tr_idx++;
            end else if (rst_n) begin
                n_checks++;
                if (obs.go !== 1'b0 || obs.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle dut %0d: got go=%b done=%b, required 0 0", sel, obs.go, obs.done);
                end
            end
            go_d = obs.go;
        end
    end

    // p1..p3: cycles with an extra start pulse (negative = random); abort_at: reset cycle.
    task automatic run(input int s, input int tgt, input int p1, input int p2, input int p3,
                       input int abort_at);
        int len, q1;
        mk_trace(s, tgt);
        len = trace_next.size() - 2;
        q1  = (p1 < 0) ? int'($urandom_range(1, len)) : p1;
        @(posedge clk); #2;
        sel = s; timer = 7'(tgt); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        trace = trace_next; tr_idx = 0; done_cycle = 0; cap.delete();
        for (int c = 1; c <= len; c++) begin
            if (c == abort_at) begin
                chk("abort_in_gohi", int'(obs.go), 1);
                trace.delete(); tr_idx = 0;
                #1 rst_n = 1'b0;
                #1 chk("abort_outputs_cleared", int'(obs), 0);
                for (int i = 0; i < 3; i++) prev_d[i] = 8'd0;
                @(posedge clk); @(posedge clk); #3;
                rst_n = 1'b1;
                return;
            end
            if (c == q1 || c == p2 || c == p3) begin
                timer = 7'(tgt) ^ 7'h2A; start = 1'b1;
            end else begin
                timer = 7'(tgt); start = 1'b0;
            end
            @(posedge clk); #2;
        end
        start = 1'b0; timer = 7'(tgt);
        for (int i = 0; i < 8 && tr_idx < trace.size(); i++) @(negedge clk);
        #1;
        chk("trace_consumed", tr_idx, trace.size());
    endtask

    task automatic chk_cap(input string nm, input int a, input int b, input int c);
        chk({nm, "_ngo"}, cap.size(), 3);
        if (cap.size() == 3) begin
            chk({nm, "_x"}, int'(cap[0]), a);
            chk({nm, "_y"}, int'(cap[1]), b);
            chk({nm, "_z"}, int'(cap[2]), c);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, tgt;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            sel = i; #1;
            chk($sformatf("reset_outputs_dut%0d", i), int'(obs), 0);
        end
        rst_n = 1'b1;
        sel = 0;

        run(0, 0, 0, 0, 0, 0);
        chk("t0_model_k", model_k, 0);
        chk("t0_done_cycle", done_cycle, 17);
        chk_cap("t0", 0, 0, 0);

        // Extra starts in SEARCH, GO_HI and the DONE cycle must all be ignored.
        run(0, 5, 100, 264, 278, 0);
        chk("t5_model_k", model_k, 261);
        chk("t5_done_cycle", done_cycle, 278);
        chk_cap("t5", 1, 0, 5);
        if (cap.size() == 3)
            chk("t5_checker_eq", (cap[0] * cap[0] * cap[2] + cap[0] * cap[1]) % 256, 5);

        run(1, 5, 3, 0, 9, 0);
        chk("nosol_found", int'(model_found), 0);
        chk("nosol_done_cycle", done_cycle, 9);
        chk("nosol_ngo", cap.size(), 0);

        run(2, 5, 0, 0, 0, 0);
        chk("gh3_done_cycle", done_cycle, 278);
        chk_cap("gh3", 1, 0, 5);

        for (int it = 0; it < 8; it++) begin
            s   = int'($urandom_range(0, 2));
            tgt = (s == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 127));
            run(s, tgt, -1, 0, 0, 0);
            if (model_found) begin
                chk("rand_ngo", cap.size(), 3);
                if (cap.size() == 3)
                    chk("rand_checker_eq", (cap[0] * cap[0] * cap[2] + cap[0] * cap[1]) % 256, tgt);
            end else begin
                chk("rand_nosol_ngo", cap.size(), 0);
            end
        end

        run(0, 5, 0, 0, 0, 269);
        run(0, 5, 0, 0, 0, 0);
        chk("after_reset_done_cycle", done_cycle, 278);
        chk_cap("after_reset", 1, 0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
